// File: rtl/demod_pkg.sv
// Shared types and constants for the QAM16 demodulator front-end arbiter.
// Four input sample bytes produce one demodulated output byte.
package demod_pkg;

  localparam int FRAME_LEN_DEF       = 256;
  localparam int QAM16_BYTES_PER_OUT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } demod_arb_state_t;

endpackage

// File: rtl/demod_rr_arb2.sv
// Two-way frame arbiter: grants one requester per frame. Grant is registered and
// held while both requests are low; advance hands priority to the source not granted.
module demod_rr_arb2 (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic req0_i,
  input  logic req1_i,
  input  logic adv_i,
  output logic gnt_o,
  output logic prio_o
);

  logic gnt_q, gnt_d;
  logic prio_q, prio_d;

  // Requests are only presented while the owner is idle, so the grant freezes for the frame.
  always_comb begin
    gnt_d = gnt_q;
    if (req0_i && !req1_i) begin
      gnt_d = 1'b0;
    end else if (req1_i && !req0_i) begin
      gnt_d = 1'b1;
    end else if (req0_i && req1_i) begin
      gnt_d = prio_q;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (adv_i) begin
      prio_d = ~gnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      gnt_q  <= 1'b0;
      prio_q <= 1'b0;
    end else begin
      gnt_q  <= gnt_d;
      prio_q <= prio_d;
    end
  end

  assign gnt_o  = gnt_q;
  assign prio_o = prio_q;

endmodule

// File: rtl/demod_arb.sv
// Whole-frame arbiter between two sample sources and a shared demodulator core; one-cycle
// registered latency on both paths. Only the granted source sees ready, and only during LOAD.
module demod_arb
  import demod_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int OUT_LEN   = FRAME_LEN / QAM16_BYTES_PER_OUT,
  parameter int TIMEOUT   = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_s0_data,
  input  logic       i_s0_valid,
  output logic       o_s0_ready,
  input  logic [7:0] i_s1_data,
  input  logic       i_s1_valid,
  output logic       o_s1_ready,
  output logic [7:0] o_dm_data,
  output logic       o_dm_enb,
  input  logic [7:0] i_dm_data,
  input  logic       i_dm_valid,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_src,
  output logic       o_last,
  output logic       o_err
);

  localparam int IN_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int OUT_W  = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  demod_arb_state_t state_q, state_d;
  logic [IN_W-1:0]   in_cnt_q, in_cnt_d;
  logic [OUT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

  logic [7:0] dm_data_q, dm_data_d;
  logic       dm_enb_q, dm_enb_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       out_src_q, out_src_d;
  logic       out_last_q, out_last_d;
  logic       err_q, err_d;

  logic       grant;
  logic       prio;
  logic       arb_adv;
  logic       in_idle;
  logic       in_load;
  logic       sel_valid;
  logic [7:0] sel_data;
  logic       accept;

  assign in_idle = (state_q == ST_IDLE);
  assign in_load = (state_q == ST_LOAD);

  demod_rr_arb2 u_arb (
    .clk_i   (i_clk),
    .rst_n_i (i_rst_n),
    .req0_i  (in_idle && i_s0_valid),
    .req1_i  (in_idle && i_s1_valid),
    .adv_i   (arb_adv),
    .gnt_o   (grant),
    .prio_o  (prio)
  );

  assign o_s0_ready = in_load && !grant;
  assign o_s1_ready = in_load && grant;
  assign sel_valid  = grant ? i_s1_valid : i_s0_valid;
  assign sel_data   = grant ? i_s1_data : i_s0_data;
  assign accept     = in_load && sel_valid;

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    dm_enb_d    = accept;
    dm_data_d   = accept ? sel_data : dm_data_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    err_d       = 1'b0;
    arb_adv     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_dm_valid) begin
          err_d = 1'b1;
        end
        if (i_s0_valid || i_s1_valid) begin
          state_d  = ST_LOAD;
          in_cnt_d = '0;
        end
      end

      ST_LOAD: begin
        if (i_dm_valid) begin
          err_d = 1'b1;
        end
        if (accept) begin
          if (in_cnt_q == IN_W'(FRAME_LEN - 1)) begin
            in_cnt_d   = '0;
            out_cnt_d  = '0;
            idle_cnt_d = '0;
            state_d    = ST_DRAIN;
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        if (i_dm_valid) begin
          out_valid_d = 1'b1;
          out_data_d  = i_dm_data;
          out_src_d   = grant;
          idle_cnt_d  = '0;
          if (out_cnt_q == OUT_W'(OUT_LEN - 1)) begin
            out_last_d = 1'b1;
            out_cnt_d  = '0;
            arb_adv    = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            out_cnt_d = out_cnt_q + 1'b1;
          end
        end else if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) begin
          // Core went quiet: abandon the frame without o_last so the other source gets a turn.
          err_d      = 1'b1;
          idle_cnt_d = '0;
          out_cnt_d  = '0;
          arb_adv    = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      dm_data_q   <= '0;
      dm_enb_q    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      dm_data_q   <= dm_data_d;
      dm_enb_q    <= dm_enb_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign o_dm_data = dm_data_q;
  assign o_dm_enb  = dm_enb_q;
  assign o_data    = out_data_q;
  assign o_valid   = out_valid_q;
  assign o_src     = out_src_q;
  assign o_last    = out_last_q;
  assign o_err     = err_q;

  a_ready_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(o_s0_ready && o_s1_ready));

  a_prio_flips: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    arb_adv |=> (prio == ~$past(grant)));

endmodule
